// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the control unit and mult_div_unit.
// master = control unit side, slave = multiply/divide unit side.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, WIDTH cycles per op.
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV via op[1]; otherwise all ops are unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MDU_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_mul;
    logic neg_quo;
    logic neg_rem;

    always_comb begin
        a_neg = bus.op[1] & bus.a[WIDTH-1];
        b_neg = bus.op[1] & bus.b[WIDTH-1];
        mag_a = a_neg ? -bus.a : bus.a;
        mag_b = b_neg ? -bus.b : bus.b;
    end
`else
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
    end
`endif

    // prod holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opnd : {WIDTH{1'b0}})};
        div_trial = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opnd};
        div_diff  = div_trial - {1'b0, opnd};
        if (is_div) begin
            step_prod = div_ge ? {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1}
                               : {prod[2*WIDTH-2:0], 1'b0};
        end else begin
            step_prod = {mul_sum, prod[WIDTH-1:1]};
        end
    end

    always_comb begin
        mul_res = step_prod;
        quo_res = step_prod[WIDTH-1:0];
        rem_res = step_prod[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
        if (neg_mul) mul_res = -step_prod;
        if (neg_quo) quo_res = -step_prod[WIDTH-1:0];
        if (neg_rem) rem_res = -step_prod[2*WIDTH-1:WIDTH];
`endif
        res_hi = is_div ? rem_res : mul_res[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo_res : mul_res[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            opnd   <= '0;
            prod   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_mul <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.we_hi) hi_r <= bus.wd;
                    if (bus.we_lo) lo_r <= bus.wd;
                    if (bus.start) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_div <= bus.op[0];
                        opnd   <= bus.op[0] ? mag_b : mag_a;
                        prod   <= {{WIDTH{1'b0}}, (bus.op[0] ? mag_a : mag_b)};
`ifdef MDU_SIGNED_EN
                        // Divide-by-zero keeps quotient all-ones; remainder negation restores a.
                        neg_mul <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        neg_quo <= (a_neg ^ b_neg) & (|bus.b);
`endif
                    end
                end
                CALC: begin
                    prod <= step_prod;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against a behavioural model,
// and hand-written reset/MTHI/MTLO/busy-interference sequences.
module tb_mult_div_unit;
`ifdef MDU_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour written with plain SV arithmetic operators.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit s;
        longint sa, sb;
        int qa, qb;
        s = SGN && op[1];
        if (!op[0]) begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            return {32'h0, a} * {32'h0, b};
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qa = $signed(a);
            qb = $signed(b);
            return {32'(qa % qb), 32'(qa / qb)};
        end
        return {a % b, a / b};
    endfunction

    // One operation: start at a negedge, track done latency, compare against the scoreboard.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit disturb,
                          input bit mt_at_start);
        int edges;
        logic [63:0] e;
        logic [63:0] got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        if (mt_at_start) begin
            bus.we_hi = 1'b1;
            bus.wd = 32'hCAFE_F00D;
        end
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        bus.we_hi = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        check({name, " busy_after_start"}, 64'(bus.busy), 64'd1);
        if (mt_at_start) check({name, " mthi_at_start"}, 64'(bus.hi), 64'hCAFE_F00D);
        edges = 0;
        while (!bus.done && edges < 40) begin
            @(negedge clk);
            edges++;
            if (disturb && edges == 5) begin
                bus.start = 1'b1;
                bus.we_hi = 1'b1;
                bus.we_lo = 1'b1;
                bus.wd = 32'hDEAD_BEEF;
                bus.op = ~op;
            end
            if (disturb && edges == 8) begin
                bus.start = 1'b0;
                bus.we_hi = 1'b0;
                bus.we_lo = 1'b0;
            end
            if (edges == 31) check({name, " busy_at_31"}, 64'(bus.busy), 64'd1);
        end
        check({name, " latency"}, 64'(edges), 64'd32);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
        got = {bus.hi, bus.lo};
        check({name, " result"}, got, e);
        check({name, " idle_in_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({name, " done_one_cycle"}, 64'(bus.done), 64'd0);
        check({name, " hold"}, {bus.hi, bus.lo}, e);
    endtask

    vec_t vecs[14];

    initial begin
        int seen;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{"multu_max_x2", 2'b00, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE};
        vecs[1]  = '{"div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'h2,
                     SGN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_7FFF_FFFC};
        vecs[2]  = '{"divu_by_zero", 2'b01, 32'h5, 32'h0, 64'h0000_0005_FFFF_FFFF};
        vecs[3]  = '{"mult_3x4", 2'b10, 32'h3, 32'h4, 64'h0000_0000_0000_000C};
        vecs[4]  = '{"multu_max_sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[5]  = '{"mult_m1_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     SGN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001};
        vecs[6]  = '{"mult_min_x2", 2'b10, 32'h8000_0000, 32'h2,
                     SGN ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0001_0000_0000};
        vecs[7]  = '{"div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                     SGN ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000};
        vecs[8]  = '{"div_neg_by_zero", 2'b11, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF};
        vecs[9]  = '{"divu_100_7", 2'b01, 32'd100, 32'd7, 64'h0000_0002_0000_000E};
        vecs[10] = '{"div_7_m2", 2'b11, 32'h7, 32'hFFFF_FFFE,
                     SGN ? 64'h0000_0001_FFFF_FFFD : 64'h0000_0007_0000_0000};
        vecs[11] = '{"divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF};
        vecs[12] = '{"mult_min_sq", 2'b10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[13] = '{"div_m7_m2", 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                     SGN ? 64'hFFFF_FFFF_0000_0003 : 64'hFFFF_FFF9_0000_0000};

        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'h1;
        bus.b = 32'h1;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wd = '0;

        // Reset held with start asserted: nothing may begin.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_reset busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0, 1'b0);
        end

        // Start/MTHI/MTLO while busy are ignored.
        run_op("busy_ignore", 2'b00, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 1'b1, 1'b0);
        @(negedge clk);
        bus.we_lo = 1'b1;
        bus.wd = 32'h1234_5678;
        @(negedge clk);
        bus.we_lo = 1'b0;
        check("mtlo_idle", {bus.hi, bus.lo}, 64'h0000_0001_1234_5678);
        bus.we_hi = 1'b1;
        bus.we_lo = 1'b1;
        bus.wd = 32'hA5A5_5A5A;
        @(negedge clk);
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        check("mthi_mtlo_both", {bus.hi, bus.lo}, 64'hA5A5_5A5A_A5A5_5A5A);

        // MTHI on the start edge is applied, then overwritten by the result.
        run_op("mthi_with_start", 2'b01, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 1'b1);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.a = 32'd3;
        bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("abort no_done", 64'(seen), 64'd0);
        run_op("mult_3x4_restart", 2'b10, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0, 1'b0);

        check("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
